mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit executing MULT, MULTU, DIV and DIVU.
//  Feeds the HI/LO register file: drives HI_input/LO_input and HI/LO write enables.
//  Raises busy so the controller stalls MFHI/MFLO/MTHI/MTLO and new mult/div ops.
//  The HI/LO file honours one write enable per cycle (LO wins), so writeback is LO then HI.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO width is WIDTH, product width is 2*WIDTH
// PORTS
//  clk              in   1      clock, rising edge
//  reset            in   1      synchronous, active-high
//  clk_enable       in   1      global stall; 0 freezes all state
//  start            in   1      issue request, sampled in IDLE only
//  op               in   2      0=MULT 1=MULTU 2=DIV 3=DIVU
//  rs_value         in   WIDTH  multiplicand / dividend
//  rt_value         in   WIDTH  multiplier / divisor
//  busy             out  1      high from the cycle after accept until return to IDLE
//  LO_output        out  WIDTH  to HI/LO file LO_input
//  HI_output        out  WIDTH  to HI/LO file HI_input
//  LO_write_enable  out  1      one-cycle pulse in WB_LO
//  HI_write_enable  out  1      one-cycle pulse in WB_HI
// BEHAVIOUR
//  - Reset: synchronous, active-high, overrides clk_enable and start.
//  - Reset values: state=IDLE; busy, both enables, HI_output, LO_output = 0.
//  - Reset mid-operation aborts the op; no write enable pulses afterwards.
//  - clk_enable=0: state, counter, datapath and outputs hold; enables stay at their current level.
//  - FSM: IDLE -> COMPUTE -> WB_LO -> WB_HI -> IDLE.
//  - IDLE: when start=1 & clk_enable=1, latch op and operand magnitudes, then go to COMPUTE.
//  - COMPUTE: exactly WIDTH enabled cycles, counter runs 0..WIDTH-1; then go to WB_LO.
//  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator, one bit per cycle.
//  - Divide: restoring division on magnitudes, one quotient bit per cycle.
//  - start while busy is ignored and is not queued.
//  - Sign rules: MULT/DIV use |x| = two's complement negate if MSB=1; MULTU/DIVU use raw values.
//  - MULT: negate the 2*WIDTH product if sign(rs)^sign(rt).
//  - DIV: quotient takes sign(rs)^sign(rt); remainder takes sign(rs).
//  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
//  - Divide by zero (DIV or DIVU): LO=all ones, HI=rs_value unmodified; no sign fix; same latency.
//  - Results: mult LO=product[W-1:0], HI=product[2W-1:W]; div LO=quotient, HI=remainder.
//  - Results are registered into LO_output/HI_output at COMPUTE exit.
//  - Outputs hold their value until the next op completes.
//  - Timing, in enabled cycles, from accept cycle T:
//      T+1..T+WIDTH  COMPUTE, busy=1
//      T+WIDTH+1     WB_LO, LO_write_enable=1, busy=1
//      T+WIDTH+2     WB_HI, HI_write_enable=1, busy=1
//      T+WIDTH+3     IDLE, busy=0; a new start can be accepted this cycle
//  - Write enables are never high together; both are decoded from the registered state.
// STRUCTURE
//  - Package mips_pkg: muldiv_op_t enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
//  - mips_pkg: muldiv_state_t enum (IDLE, COMPUTE, WB_LO, WB_HI).
//  - mips_pkg: function twos_abs(); constant MULDIV_CNT_W = $clog2(WIDTH).
//  - Single module; no sub-module. The mult and div datapaths share the accumulator and counter.
// TESTING
//  - MULT 7 * 0xFFFFFFFD -> LO=0xFFFFFFEB, HI=0xFFFFFFFF.
//      LO enable at T+33, HI enable at T+34, busy low at T+35.
//  - MULTU 0xFFFFFFFF * 0xFFFFFFFF -> LO=0x00000001, HI=0xFFFFFFFE.
//  - DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU 100 / 7 -> LO=0x0000000E, HI=0x00000002.
//  - DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
//      DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  - Reset at T+10 -> busy=0 next cycle, outputs 0, no enable pulse ever.
//      A start during busy leaves results and timing unchanged.
//  - clk_enable low for 5 cycles during COMPUTE -> both enable pulses shift 5 cycles later.
//      Results are unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS multiply/divide unit.
// The operand width here is the default width of mult_div_unit.
package mips_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    WB_LO   = 2'd2,
    WB_HI   = 2'd3
  } muldiv_state_t;

  // Magnitude of a two's complement value.
  // The most negative value maps to itself and reads correctly as unsigned.
  function automatic logic [MULDIV_WIDTH-1:0] twos_abs(input logic [MULDIV_WIDTH-1:0] x);
    return x[MULDIV_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register file.
// Results are written back as LO first, then HI, over two cycles.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic             busy,
  output logic [WIDTH-1:0] LO_output,
  output logic [WIDTH-1:0] HI_output,
  output logic             LO_write_enable,
  output logic             HI_write_enable,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: start is accepted only when the unit is IDLE and clk_enable
  // is high; busy stays high from the next cycle until the unit is IDLE again.
  // A start seen while busy is dropped and not queued.

  muldiv_state_t          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  muldiv_op_t             op_q, op_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       divs_q, divs_d;
  logic [WIDTH-1:0]       rs_raw_q, rs_raw_d;
  logic                   neg_q, neg_d;
  logic                   negr_q, negr_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic [WIDTH-1:0]       hi_q, hi_d;

  muldiv_op_t             op_in;
  logic                   signed_in;
  logic                   is_div;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         div_sh;
  logic [WIDTH:0]         div_diff;
  logic [2*WIDTH-1:0]     div_next;
  logic [2*WIDTH-1:0]     step;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quot_fix;
  logic [WIDTH-1:0]       rem_fix;

  assign op_in     = muldiv_op_t'(op);
  assign signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Multiply: accumulator is {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? divs_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: accumulator is {partial remainder, dividend/quotient bits}.
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, divs_q};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign step     = is_div ? div_next : mul_next;
  assign prod_fix = neg_q ? (~step + 1'b1) : step;
  assign quot_fix = neg_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
  assign rem_fix  = negr_q ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    divs_d   = divs_q;
    rs_raw_d = rs_raw_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COMPUTE;
          cnt_d    = '0;
          op_d     = op_in;
          rs_raw_d = rs_value;
          acc_d    = {{WIDTH{1'b0}}, (signed_in ? twos_abs(rs_value) : rs_value)};
          divs_d   = signed_in ? twos_abs(rt_value) : rt_value;
          neg_d    = signed_in && (rs_value[WIDTH-1] ^ rt_value[WIDTH-1]);
          negr_d   = signed_in && rs_value[WIDTH-1];
        end
      end
      COMPUTE: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = WB_LO;
          cnt_d   = '0;
          if (!is_div) begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end else if (divs_q == '0) begin
            // Divide by zero bypasses the sign fix and returns the raw dividend.
            lo_d = '1;
            hi_d = rs_raw_q;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end
      end
      WB_LO:   state_d = WB_HI;
      WB_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      acc_q    <= '0;
      divs_q   <= '0;
      rs_raw_q <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      divs_q   <= divs_d;
      rs_raw_q <= rs_raw_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign LO_write_enable = (state_q == WB_LO);
  assign HI_write_enable = (state_q == WB_HI);
  assign LO_output       = lo_q;
  assign HI_output       = hi_q;
  assign dbg_state       = state_q;

endmodule
